// File: rtl/neuron_mac_sequencer.sv
// Single-neuron MAC sequencer: streams COUNT activations and weights, accumulates onto a
// scaled bias, applies ReLU with saturation, and writes the result back to the neuron RAM.
module neuron_mac_sequencer #(
  parameter int unsigned DATA_BUS_WIDTH    = 8,
  parameter int unsigned ADDRESS_BUS_WIDTH = 16,
  parameter int unsigned ACC_WIDTH         = 24,
  parameter int unsigned FRAC_BITS         = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDRESS_BUS_WIDTH-1:0] src_base,
  input  logic [ADDRESS_BUS_WIDTH-1:0] dst_address,
  input  logic [ADDRESS_BUS_WIDTH-1:0] count,
  input  logic [DATA_BUS_WIDTH-1:0]    bias,
  output logic [ADDRESS_BUS_WIDTH-1:0] weight_address,
  input  logic [DATA_BUS_WIDTH-1:0]    weight_data,
  output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
  output logic                         oe,
  input  logic [DATA_BUS_WIDTH-1:0]    read_data,
  output logic [ADDRESS_BUS_WIDTH-1:0] write_address,
  output logic [DATA_BUS_WIDTH-1:0]    write_data,
  output logic                         wre,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned DW = DATA_BUS_WIDTH;
  localparam int unsigned AW = ADDRESS_BUS_WIDTH;
  localparam int unsigned CW = ACC_WIDTH;
  localparam logic signed [CW-1:0] SAT_MAX = CW'((1 << (DW - 1)) - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic signed [CW-1:0] acc_q, acc_d;
  logic [AW-1:0]        src_q, src_d;
  logic [AW-1:0]        dst_q, dst_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic                 oe_q, oe_d;
  logic                 wre_q, wre_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic [AW-1:0]        w_addr_q, w_addr_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [DW-1:0]        wr_data_q, wr_data_d;
  logic signed [2*DW-1:0] prod;

  // Negative sums clamp to zero; positive sums drop the fraction and clip to the max code.
  function automatic logic [DW-1:0] relu_sat(input logic signed [CW-1:0] a);
    logic signed [CW-1:0] s;
    s = a >>> FRAC_BITS;
    if (a < 0) return '0;
    if (s > SAT_MAX) return DW'(SAT_MAX);
    return DW'(s);
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    oe_d      = 1'b0;
    wre_d     = 1'b0;
    done_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    w_addr_d  = w_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    prod      = $signed(read_data) * $signed(weight_data);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d = src_base;
          dst_d = dst_address;
          cnt_d = count;
          idx_d = '0;
          acc_d = CW'($signed(bias)) <<< FRAC_BITS;
          if (count != '0) begin
            state_d   = ACCUM;
            oe_d      = 1'b1;
            rd_addr_d = src_base;
            w_addr_d  = '0;
          end else begin
            state_d   = WRITE;
            wre_d     = 1'b1;
            wr_addr_d = dst_address;
            wr_data_d = relu_sat(acc_d);
          end
        end
      end
      ACCUM: begin
        acc_d = acc_q + CW'(prod);
        idx_d = idx_q + AW'(1);
        if (idx_q == cnt_q - AW'(1)) begin
          state_d   = WRITE;
          wre_d     = 1'b1;
          wr_addr_d = dst_q;
          wr_data_d = relu_sat(acc_d);
        end else begin
          oe_d      = 1'b1;
          rd_addr_d = src_q + idx_d;
          w_addr_d  = idx_d;
        end
      end
      WRITE: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      oe_q      <= 1'b0;
      wre_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_addr_q <= '0;
      w_addr_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      oe_q      <= oe_d;
      wre_q     <= wre_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_addr_q <= rd_addr_d;
      w_addr_q  <= w_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign oe             = oe_q;
  assign wre            = wre_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign read_address   = rd_addr_q;
  assign weight_address = w_addr_q;
  assign write_address  = wr_addr_q;
  assign write_data     = wr_data_q;

endmodule
